// File: rtl/aes128_key_expand_seq_if.sv
// Handshake bundle between the key-schedule block and its round-key consumer.
// AES_KS_REVERSE_EN adds the reverse request bit sampled alongside start.
interface aes128_key_expand_seq_if;
    logic         start;
    logic [127:0] cipher_key;
`ifdef AES_KS_REVERSE_EN
    logic         reverse;
`endif
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    modport master (
        output start,
        output cipher_key,
`ifdef AES_KS_REVERSE_EN
        output reverse,
`endif
        output rk_ready,
        input  rk_valid,
        input  round_key,
        input  round_idx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  cipher_key,
`ifdef AES_KS_REVERSE_EN
        input  reverse,
`endif
        input  rk_ready,
        output rk_valid,
        output round_key,
        output round_idx,
        output busy,
        output done
    );
endinterface

// File: rtl/aes128_key_expand_seq.sv
// AES-128 key schedule, one shared S-box, round keys 0..10 over valid/ready.
// Define AES_KS_REVERSE_EN for the 11-entry store and 10-down-to-0 replay mode.
module aes128_key_expand_seq (
    input  logic                          clk,
    input  logic                          asy_reset,
    aes128_key_expand_seq_if.slave        ks
);

    typedef enum logic [3:0] {
        S_IDLE, S_EMIT, S_SUB0, S_SUB1, S_SUB2, S_SUB3, S_MIX
`ifdef AES_KS_REVERSE_EN
        , S_FILL, S_REPLAY
`endif
    } state_t;

    // Byte i of the table lives at bit offset 8*(255-i).
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [31:0]  t_q, t_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;

    logic [31:0]  rot, tr, w0n, w1n, w2n, w3n;
    logic [127:0] mix_w;
    logic [7:0]   sb_in, sb_out, rcon;

`ifdef AES_KS_REVERSE_EN
    logic         rev_q, rev_d;
    logic [127:0] store_q [11];
    logic         st_we;
    logic [3:0]   st_addr;
    logic [127:0] st_data;
`endif

    assign rot    = {key_q[23:0], key_q[31:24]};
    assign sb_out = SBOX_TBL[{~sb_in, 3'b000} +: 8];

    always_comb begin
        case (idx_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign tr    = t_q ^ {rcon, 24'h0};
    assign w0n   = key_q[127:96] ^ tr;
    assign w1n   = key_q[95:64]  ^ w0n;
    assign w2n   = key_q[63:32]  ^ w1n;
    assign w3n   = key_q[31:0]   ^ w2n;
    assign mix_w = {w0n, w1n, w2n, w3n};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        t_d     = t_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        sb_in   = rot[31:24];
`ifdef AES_KS_REVERSE_EN
        rev_d   = rev_q;
        st_we   = 1'b0;
        st_addr = idx_q;
        st_data = ks.cipher_key;
`endif
        case (state_q)
            S_IDLE: begin
                if (ks.start) begin
                    key_d   = ks.cipher_key;
                    idx_d   = '0;
                    state_d = S_EMIT;
`ifdef AES_KS_REVERSE_EN
                    rev_d   = ks.reverse;
                    if (ks.reverse) begin
                        st_we   = 1'b1;
                        st_addr = '0;
                        state_d = S_FILL;
                    end
`endif
                end
            end
            S_EMIT: begin
                if (ks.rk_ready) begin
                    if (idx_q == 4'd10) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SUB0;
                    end
                end
            end
`ifdef AES_KS_REVERSE_EN
            // FILL doubles as SUB0 while generating into the store.
            S_SUB0, S_FILL: begin
`else
            S_SUB0: begin
`endif
                t_d[31:24] = sb_out;
                state_d    = S_SUB1;
            end
            S_SUB1: begin
                sb_in      = rot[23:16];
                t_d[23:16] = sb_out;
                state_d    = S_SUB2;
            end
            S_SUB2: begin
                sb_in      = rot[15:8];
                t_d[15:8]  = sb_out;
                state_d    = S_SUB3;
            end
            S_SUB3: begin
                sb_in      = rot[7:0];
                t_d[7:0]   = sb_out;
                state_d    = S_MIX;
            end
            S_MIX: begin
                key_d   = mix_w;
                idx_d   = idx_q + 4'd1;
                state_d = S_EMIT;
`ifdef AES_KS_REVERSE_EN
                if (rev_q) begin
                    st_we   = 1'b1;
                    st_addr = idx_q + 4'd1;
                    st_data = mix_w;
                    state_d = (idx_q == 4'd9) ? S_REPLAY : S_FILL;
                end
`endif
            end
`ifdef AES_KS_REVERSE_EN
            S_REPLAY: begin
                if (ks.rk_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge asy_reset) begin
        if (!asy_reset) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            t_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            t_q     <= t_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

`ifdef AES_KS_REVERSE_EN
    always_ff @(posedge clk or negedge asy_reset) begin
        if (!asy_reset) begin
            rev_q <= 1'b0;
            for (int unsigned i = 0; i < 11; i++) store_q[i] <= '0;
        end else begin
            rev_q <= rev_d;
            if (st_we) store_q[st_addr] <= st_data;
        end
    end

    assign ks.rk_valid  = (state_q == S_EMIT) || (state_q == S_REPLAY);
    assign ks.round_key = (state_q == S_REPLAY) ? store_q[idx_q] : key_q;
`else
    assign ks.rk_valid  = (state_q == S_EMIT);
    assign ks.round_key = key_q;
`endif
    assign ks.round_idx = idx_q;
    assign ks.busy      = (state_q != S_IDLE);
    assign ks.done      = done_q;

endmodule

// File: tb/tb_aes128_key_expand_seq.sv
// Bench for aes128_key_expand_seq against a FIPS-197 word-array key expansion model.
// Reverse replay is exercised only when AES_KS_REVERSE_EN is defined.
module tb_aes128_key_expand_seq;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1_A1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk = 1'b0;
    logic asy_reset;
    aes128_key_expand_seq_if ks();

    aes128_key_expand_seq dut (.clk(clk), .asy_reset(asy_reset), .ks(ks));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]   sb [256];
    logic [127:0] exp_rk [11];
    logic [127:0] obs_key [$];
    int           obs_idx [$];
    int           obs_cyc [$];
    int           start_cyc, done_cyc, dones;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic launch(input logic [127:0] key, input bit rev);
        obs_key.delete(); obs_idx.delete(); obs_cyc.delete();
        dones = 0;
        ks.start = 1'b1;
        ks.cipher_key = key;
`ifdef AES_KS_REVERSE_EN
        ks.reverse = rev;
`else
        if (rev) $display("note: reverse mode not built, running forward");
`endif
        @(negedge clk);
        ks.start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic step(input bit rdy);
        ks.rk_ready = rdy;
        if (ks.rk_valid && rdy) begin
            obs_key.push_back(ks.round_key);
            obs_idx.push_back(int'(ks.round_idx));
            obs_cyc.push_back(cyc + 1);
        end
        @(negedge clk);
    endtask

    // Runs until done is seen; returns on the done cycle without advancing.
    task automatic finish_run(input int unsigned pct);
        for (int k = 0; k < 1000; k++) begin
            if (ks.done) begin
                dones++;
                done_cyc = cyc;
                break;
            end
            step($urandom_range(99) < pct);
        end
        n_cmp++;
        if (dones == 0) begin
            n_err++;
            $display("FAIL run_timeout: done never seen, required within 1000 cycles");
        end
    endtask

    task automatic run_to_idx(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (ks.rk_valid && int'(ks.round_idx) == n) begin
                ok = 1'b1;
                return;
            end
            step(1'b1);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({ks.rk_valid, ks.busy, ks.done, ks.round_idx, ks.round_key} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b busy=%b done=%b idx=%0d key=%h, required all 0",
                     ks.rk_valid, ks.busy, ks.done, ks.round_idx, ks.round_key);
        end
        asy_reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ks.busy !== 1'b0 || ks.rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b valid=%b, required 0 0", ks.busy, ks.rk_valid);
        end
    endtask

    task automatic test_fips_forward();
        model_expand(KEY_A1);
        launch(KEY_A1, 1'b0);
        finish_run(100);
        n_cmp++;
        if (obs_key.size() != 11) begin
            n_err++;
            $display("FAIL fips_count: got %0d transfers, required 11", obs_key.size());
        end
        for (int i = 0; i < obs_key.size() && i < 11; i++) begin
            n_cmp++;
            if (obs_key[i] !== exp_rk[i] || obs_idx[i] != i || obs_cyc[i] - start_cyc != 1 + 6*i) begin
                n_err++;
                $display("FAIL fips_rk%0d: key=%h idx=%0d at=%0d, required %h idx=%0d at=%0d", i,
                         obs_key[i], obs_idx[i], obs_cyc[i] - start_cyc, exp_rk[i], i, 1 + 6*i);
            end
        end
        if (obs_key.size() == 11) begin
            n_cmp++;
            if (obs_key[0] !== KEY_A1 || obs_key[1] !== RK1_A1 || obs_key[10] !== RK10_A1) begin
                n_err++;
                $display("FAIL fips_vectors: rk0=%h rk1=%h rk10=%h, required %h %h %h",
                         obs_key[0], obs_key[1], obs_key[10], KEY_A1, RK1_A1, RK10_A1);
            end
        end
        n_cmp++;
        if (done_cyc - start_cyc != 61) begin
            n_err++;
            $display("FAIL fips_done_time: done at %0d cycles, required 61", done_cyc - start_cyc);
        end
        ks.rk_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ks.done !== 1'b0 || ks.busy !== 1'b0) begin
            n_err++;
            $display("FAIL fips_done_pulse: done=%b busy=%b a cycle later, required 0 0", ks.done, ks.busy);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] key = rand_key();
        logic [127:0] held;
        bit ok;
        int t_edge;
        model_expand(key);
        launch(key, 1'b0);
        run_to_idx(3, ok);
        held = ks.round_key;
        n_cmp++;
        if (!ok || held !== exp_rk[3]) begin
            n_err++;
            $display("FAIL bp_reach_idx3: reached=%0d key=%h, required 1 %h", ok, held, exp_rk[3]);
        end
        for (int c = 0; c < 7; c++) begin
            step(1'b0);
            n_cmp++;
            if (ks.rk_valid !== 1'b1 || ks.round_key !== held || ks.round_idx !== 4'd3) begin
                n_err++;
                $display("FAIL bp_hold%0d: valid=%b idx=%0d key=%h, required 1 3 %h",
                         c, ks.rk_valid, ks.round_idx, ks.round_key, held);
            end
        end
        step(1'b1);
        t_edge = cyc;
        for (int k = 0; k < 20 && !ks.rk_valid; k++) step(1'b0);
        n_cmp++;
        if (cyc - t_edge != 5 || ks.round_idx !== 4'd4 || ks.round_key !== exp_rk[4]) begin
            n_err++;
            $display("FAIL bp_next_latency: %0d cycles idx=%0d key=%h, required 5 4 %h",
                     cyc - t_edge, ks.round_idx, ks.round_key, exp_rk[4]);
        end
        finish_run(100);
        n_cmp++;
        if (obs_key.size() != 11 || obs_key[10] !== exp_rk[10] || obs_key[3] !== exp_rk[3]) begin
            n_err++;
            $display("FAIL bp_sequence: count=%0d, required 11 matching keys", obs_key.size());
        end
        ks.rk_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        logic [127:0] key_a = rand_key();
        logic [127:0] key_b = ~key_a;
        bit ok;
        model_expand(key_a);
        launch(key_a, 1'b0);
        run_to_idx(5, ok);
        ks.start = 1'b1;
        ks.cipher_key = key_b;
        step(1'b1);
        step(1'b1);
        ks.start = 1'b0;
        finish_run(100);
        n_cmp++;
        if (!ok || obs_key.size() != 11) begin
            n_err++;
            $display("FAIL ign_count: reached=%0d count=%0d, required 1 11", ok, obs_key.size());
        end
        for (int i = 5; i < obs_key.size() && i < 11; i++) begin
            n_cmp++;
            if (obs_key[i] !== exp_rk[i] || obs_idx[i] != i) begin
                n_err++;
                $display("FAIL ign_rk%0d: key=%h idx=%0d, required %h %0d",
                         i, obs_key[i], obs_idx[i], exp_rk[i], i);
            end
        end
        ks.rk_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] key = rand_key();
        bit ok;
        launch(key, 1'b0);
        run_to_idx(5, ok);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        n_cmp++;
        if (!ok || ks.busy !== 1'b1 || ks.rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_pre: reached=%0d busy=%b valid=%b, required 1 1 0", ok, ks.busy, ks.rk_valid);
        end
        #2 asy_reset = 1'b0;
        #1;
        n_cmp++;
        if ({ks.rk_valid, ks.busy, ks.done, ks.round_idx, ks.round_key} !== '0) begin
            n_err++;
            $display("FAIL rst_async: valid=%b busy=%b done=%b idx=%0d key=%h, required all 0",
                     ks.rk_valid, ks.busy, ks.done, ks.round_idx, ks.round_key);
        end
        @(negedge clk);
        asy_reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ks.busy !== 1'b0 || ks.rk_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_wait_start: busy=%b valid=%b, required 0 0", ks.busy, ks.rk_valid);
        end
        key = rand_key();
        model_expand(key);
        launch(key, 1'b0);
        finish_run(70);
        n_cmp++;
        if (obs_key.size() != 11) begin
            n_err++;
            $display("FAIL rst_rerun_count: got %0d, required 11", obs_key.size());
        end
        for (int i = 0; i < obs_key.size() && i < 11; i++) begin
            n_cmp++;
            if (obs_key[i] !== exp_rk[i] || obs_idx[i] != i) begin
                n_err++;
                $display("FAIL rst_rerun_rk%0d: key=%h idx=%0d, required %h %0d",
                         i, obs_key[i], obs_idx[i], exp_rk[i], i);
            end
        end
        ks.rk_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] key = rand_key();
        logic [127:0] first [$];
        model_expand(key);
        launch(key, 1'b0);
        finish_run(100);
        first = obs_key;
        launch(key, 1'b0);
        finish_run(100);
        n_cmp++;
        if (obs_key.size() != 11 || first.size() != 11 || done_cyc - start_cyc != 61) begin
            n_err++;
            $display("FAIL b2b_shape: counts=%0d/%0d done_at=%0d, required 11/11 61",
                     first.size(), obs_key.size(), done_cyc - start_cyc);
        end
        for (int i = 0; i < obs_key.size() && i < first.size() && i < 11; i++) begin
            n_cmp++;
            if (obs_key[i] !== first[i] || obs_key[i] !== exp_rk[i]) begin
                n_err++;
                $display("FAIL b2b_rk%0d: run2=%h run1=%h, required %h", i, obs_key[i], first[i], exp_rk[i]);
            end
        end
        ks.rk_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            logic [127:0] key = rand_key();
            model_expand(key);
            launch(key, 1'b0);
            finish_run($urandom_range(90, 30));
            n_cmp++;
            if (obs_key.size() != 11) begin
                n_err++;
                $display("FAIL rnd%0d_count: got %0d, required 11", r, obs_key.size());
            end
            for (int i = 0; i < obs_key.size() && i < 11; i++) begin
                n_cmp++;
                if (obs_key[i] !== exp_rk[i] || obs_idx[i] != i ||
                    (i > 0 && obs_cyc[i] - obs_cyc[i-1] < 6)) begin
                    n_err++;
                    $display("FAIL rnd%0d_rk%0d: key=%h idx=%0d, required %h %0d",
                             r, i, obs_key[i], obs_idx[i], exp_rk[i], i);
                end
            end
            ks.rk_ready = 1'b0;
        end
    endtask

`ifdef AES_KS_REVERSE_EN
    task automatic test_reverse();
        for (int r = 0; r < 2; r++) begin
            logic [127:0] key = (r == 0) ? KEY_A1 : rand_key();
            int unsigned pct = (r == 0) ? 100 : 60;
            model_expand(key);
            launch(key, 1'b1);
            finish_run(pct);
            n_cmp++;
            if (obs_key.size() != 11) begin
                n_err++;
                $display("FAIL rev%0d_count: got %0d, required 11", r, obs_key.size());
            end
            for (int i = 0; i < obs_key.size() && i < 11; i++) begin
                n_cmp++;
                if (obs_key[i] !== exp_rk[10-i] || obs_idx[i] != 10 - i) begin
                    n_err++;
                    $display("FAIL rev%0d_pos%0d: key=%h idx=%0d, required %h %0d",
                             r, i, obs_key[i], obs_idx[i], exp_rk[10-i], 10 - i);
                end
            end
            if (r == 0 && obs_key.size() == 11) begin
                n_cmp++;
                if (obs_key[0] !== RK10_A1 || obs_key[10] !== KEY_A1 || obs_cyc[0] - start_cyc != 51 ||
                    obs_cyc[10] - obs_cyc[0] != 10) begin
                    n_err++;
                    $display("FAIL rev_fips: first=%h last=%h first_at=%0d span=%0d, required %h %h 51 10",
                             obs_key[0], obs_key[10], obs_cyc[0] - start_cyc,
                             obs_cyc[10] - obs_cyc[0], RK10_A1, KEY_A1);
                end
            end
            ks.rk_ready = 1'b0;
            ks.reverse = 1'b0;
        end
    endtask
`endif

    initial begin
        asy_reset = 1'b0;
        ks.start = 1'b0;
        ks.cipher_key = '0;
        ks.rk_ready = 1'b0;
`ifdef AES_KS_REVERSE_EN
        ks.reverse = 1'b0;
`endif
        build_sbox();
        repeat (3) @(negedge clk);
        test_reset();
        test_fips_forward();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef AES_KS_REVERSE_EN
        test_reverse();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
